mandel_pixel_scheduler: RTL and testbench
=========================================

Name: mandel_pixel_scheduler

Overview:
- Frame-level controller that farms Mandelbrot pixels out to N_ITER parallel fsm_iterator-style workers.
- Generates per-pixel complex coordinates (c_r, c_i) in 4.23 fixed point by raster scan and dispatches them round-robin to idle workers.
- Collects finished iteration counts round-robin and emits them as an addressed pixel stream to the frame-buffer writer.
- Sits between the host/config registers and the iterator array.

Parameters:
- N_ITER, 4, number of iterator workers (2..16)
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ITER_W, 11, width of worker iter_count (clog2(ITER_MAX)+1)
- ADDR_W, 19, pixel address width, >= clog2(H_RES*V_RES)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin frame; sampled only in IDLE
- cr_origin  in  27  c_r of pixel (0,0), signed 4.23
- ci_origin  in  27  c_i of pixel (0,0), signed 4.23
- dx  in  27  signed c_r step per column
- dy  in  27  signed c_i step per line
- busy  out  1  high in RUN/DRAIN
- frame_done  out  1  one-cycle pulse at frame end
- wk_in_val  out  N_ITER  per-worker dispatch valid
- wk_in_rdy  in  N_ITER  per-worker idle/ready
- wk_c_r  out  27*N_ITER  per-worker c_r (slice i = bits 27i+26:27i)
- wk_c_i  out  27*N_ITER  per-worker c_i
- wk_out_val  in  N_ITER  worker result valid
- wk_out_rdy  out  N_ITER  result accept
- wk_iter  in  ITER_W*N_ITER  worker iter_count
- px_val  out  1  pixel result valid
- px_rdy  in  1  frame-buffer writer ready
- px_addr  out  ADDR_W  y*H_RES+x of result
- px_iter  out  ITER_W  iteration count
- frame_cycles  out  32  cycles in last frame (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, frame_done=0, wk_in_val=0, wk_out_rdy=0, px_val=0, px_addr=0, px_iter=0; x,y, coordinate accumulators, outstanding count, both RR pointers = 0; frame_cycles=0. Workers are reset separately; mid-frame reset abandons the frame, no frame_done.
- States:
  - IDLE: start=1 -> RUN next edge. Latch origins/steps; cur_cr=cr_origin, cur_ci=ci_origin, x=y=0.
  - RUN: dispatch while pixels remain. After the last dispatch -> DRAIN.
  - DRAIN: collect only. Outstanding==0 -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Dispatch:
  - At most one pixel per cycle, RUN only.
  - Dispatch arbiter grants the first index at/after disp_ptr with wk_in_rdy=1. Only that worker sees wk_in_val=1 (combinational from grant).
  - wk_c_r/wk_c_i of every slice are driven with cur_cr/cur_ci.
  - Transfer occurs on wk_in_val&wk_in_rdy. On transfer:
    - tag[g]<=y*H_RES+x (address kept in scheduler; workers carry no tag).
    - disp_ptr<=g+1 mod N_ITER.
    - x++ and cur_cr+=dx. At x==H_RES-1: x<=0, cur_cr<=cr_origin, y++, cur_ci+=dy.
  - All coordinate adds are 27-bit two's-complement wrap; no saturation.
- Collect:
  - Collect arbiter grants the first index at/after coll_ptr with wk_out_val=1.
  - px_val=1 whenever any wk_out_val=1 and state is RUN/DRAIN. px_addr=tag[g], px_iter=wk_iter slice g.
  - wk_out_rdy[g]=px_rdy for the granted worker only. On px_val&px_rdy, coll_ptr<=g+1 mod N_ITER.
  - px_val/px_addr/px_iter hold stable while px_rdy=0 (grant frozen until transfer).
- Outstanding counter (width clog2(N_ITER)+1): +1 on dispatch, -1 on collect, unchanged when both occur in the same cycle.
- A worker cannot be dispatched and collected in the same cycle (in_rdy and out_val are mutually exclusive per worker); a dispatch and a collect on different workers in one cycle are both legal.
- All workers busy: no dispatch, no stall of coordinates. px_rdy=0: results back up in the workers without loss.
- Latency: start -> first wk_in_val = 1 cycle. Last collect -> frame_done = 1 cycle.

Optional Feature:
- PERF_COUNT_EN defined: 32-bit counter clears on the IDLE->RUN transition and increments every RUN/DRAIN cycle. It is copied to frame_cycles on entry to DONE, and saturates at all-ones.
- Undefined: no counter logic; frame_cycles is tied to 0.

Decomposition:
- Shared package mandel_pkg: FX_W=27, FX_FRAC=23, ITER_W, state encoding localparams (IDLE, RUN, DRAIN, DONE).
- Natural sub-module: rr_arbiter (N-way request, pointer input, one-hot grant plus index). Instantiated twice, for dispatch and collect.

Test Plan:
- H_RES=4, V_RES=2, N_ITER=2; stub workers return iter=addr+1 after 3 cycles, px_rdy=1 -> 8 px transfers with addrs 0..7 each exactly once, px_iter=addr+1, single frame_done, busy low after.
- cr_origin=-2.0 (27'h7000000), dx=0.5 (27'h0400000), ci_origin=1.0, dy=-0.5 -> pixel 5 dispatched with c_r=-1.5, c_i=0.5; line start resets c_r to -2.0.
- px_rdy held 0 for 20 cycles mid-frame -> px_val/px_addr/px_iter stable, no dispatch beyond N_ITER outstanding, no result lost after release.
- Worker 0 permanently in_rdy=0 -> all pixels dispatched to worker 1, frame completes; alternating workers otherwise checked by round-robin order 0,1,0,1.
- reset pulsed low for 1 cycle mid-RUN -> all outputs zero immediately, IDLE, no frame_done; new start runs a clean frame.
- PERF_COUNT_EN defined, px_rdy=1, fixed 3-cycle workers -> frame_cycles equals measured RUN+DRAIN cycle count; undefined -> reads 0.

Source files
------------

// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared fixed-point widths and FSM encoding for the Mandelbrot pixel scheduler
package mandel_pkg;
    localparam int FX_W    = 27;
    localparam int FX_FRAC = 23;
    localparam int ITER_W  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;
endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// rtl/mandel_pixel_scheduler_if.sv - worker dispatch/collect bus and addressed pixel stream
interface mandel_pixel_scheduler_if #(
    parameter int N_ITER = 4,
    parameter int ITER_W = 11,
    parameter int ADDR_W = 19
);
    logic [N_ITER-1:0]                    wk_in_val;
    logic [N_ITER-1:0]                    wk_in_rdy;
    logic [mandel_pkg::FX_W*N_ITER-1:0]   wk_c_r;
    logic [mandel_pkg::FX_W*N_ITER-1:0]   wk_c_i;
    logic [N_ITER-1:0]                    wk_out_val;
    logic [N_ITER-1:0]                    wk_out_rdy;
    logic [ITER_W*N_ITER-1:0]             wk_iter;
    logic                                 px_val;
    logic                                 px_rdy;
    logic [ADDR_W-1:0]                    px_addr;
    logic [ITER_W-1:0]                    px_iter;

    modport master (
        output wk_in_val, wk_c_r, wk_c_i, wk_out_rdy, px_val, px_addr, px_iter,
        input  wk_in_rdy, wk_out_val, wk_iter, px_rdy
    );

    modport slave (
        input  wk_in_val, wk_c_r, wk_c_i, wk_out_rdy, px_val, px_addr, px_iter,
        output wk_in_rdy, wk_out_val, wk_iter, px_rdy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first requester at or after ptr wins
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mandel_pixel_scheduler.sv
// rtl/mandel_pixel_scheduler.sv - raster pixel dispatch to N_ITER workers and addressed result collection
// PERF_COUNT_EN: when defined, frame_cycles reports RUN+DRAIN cycles of the last frame.
module mandel_pixel_scheduler #(
    parameter int N_ITER = 4,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ITER_W = 11,
    parameter int ADDR_W = 19
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [mandel_pkg::FX_W-1:0] cr_origin,
    input  logic [mandel_pkg::FX_W-1:0] ci_origin,
    input  logic [mandel_pkg::FX_W-1:0] dx,
    input  logic [mandel_pkg::FX_W-1:0] dy,
    output logic                        busy,
    output logic                        frame_done,
    output logic [31:0]                 frame_cycles,
    mandel_pixel_scheduler_if.master    bus
);
    import mandel_pkg::*;

    localparam int IDX_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int OUT_W = $clog2(N_ITER) + 1;
    localparam int XW    = $clog2(H_RES) + 1;
    localparam int YW    = $clog2(V_RES) + 1;

    sched_state_t      state, state_nx;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;
    logic [FX_W-1:0]   cur_cr, cur_ci, cr0_q, dx_q, dy_q;
    logic [IDX_W-1:0]  disp_ptr, coll_ptr, lock_idx, d_idx, c_idx, c_sel;
    logic [N_ITER-1:0] d_grant, c_grant, c_sel_oh;
    logic              d_any, c_any, coll_lock;
    logic              active, frame_start, disp_fire, coll_fire, px_val_i, last_px;
    logic [OUT_W-1:0]  outst, out_nx;
    logic [ADDR_W-1:0] tag [N_ITER];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_ITER - 1) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(.N(N_ITER), .IDX_W(IDX_W)) u_disp_arb (
        .req(bus.wk_in_rdy), .ptr(disp_ptr), .grant(d_grant), .idx(d_idx), .valid(d_any)
    );

    rr_arbiter #(.N(N_ITER), .IDX_W(IDX_W)) u_coll_arb (
        .req(bus.wk_out_val), .ptr(coll_ptr), .grant(c_grant), .idx(c_idx), .valid(c_any)
    );

    // A stalled result keeps its grant so the stream stays stable until px_rdy returns.
    always_comb begin
        active      = (state == RUN) || (state == DRAIN);
        frame_start = (state == IDLE) && start;
        disp_fire   = (state == RUN) && d_any;
        c_sel       = coll_lock ? lock_idx : c_idx;
        c_sel_oh    = coll_lock ? (N_ITER'(1) << lock_idx) : c_grant;
        px_val_i    = active && (coll_lock || c_any);
        coll_fire   = px_val_i && bus.px_rdy;
        last_px     = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
        out_nx      = outst + OUT_W'(disp_fire) - OUT_W'(coll_fire);

        bus.wk_in_val  = disp_fire ? d_grant : '0;
        bus.wk_c_r     = {N_ITER{cur_cr}};
        bus.wk_c_i     = {N_ITER{cur_ci}};
        bus.wk_out_rdy = coll_fire ? c_sel_oh : '0;
        bus.px_val     = px_val_i;
        bus.px_addr    = px_val_i ? tag[c_sel] : '0;
        bus.px_iter    = px_val_i ? bus.wk_iter[c_sel*ITER_W +: ITER_W] : '0;

        busy       = active;
        frame_done = (state == DONE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (disp_fire && last_px) state_nx = DRAIN;
            DRAIN:   if (out_nx == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            cur_cr    <= '0;
            cur_ci    <= '0;
            cr0_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            disp_ptr  <= '0;
            coll_ptr  <= '0;
            outst     <= '0;
            coll_lock <= 1'b0;
            lock_idx  <= '0;
            for (int i = 0; i < N_ITER; i++) tag[i] <= '0;
        end else begin
            if (frame_start) begin
                cr0_q  <= cr_origin;
                dx_q   <= dx;
                dy_q   <= dy;
                cur_cr <= cr_origin;
                cur_ci <= ci_origin;
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else if (disp_fire) begin
                tag[d_idx] <= addr_q;
                addr_q     <= addr_q + ADDR_W'(1);
                disp_ptr   <= next_idx(d_idx);
                if (x_q == XW'(H_RES - 1)) begin
                    x_q    <= '0;
                    cur_cr <= cr0_q;
                    y_q    <= y_q + YW'(1);
                    cur_ci <= cur_ci + dy_q;
                end else begin
                    x_q    <= x_q + XW'(1);
                    cur_cr <= cur_cr + dx_q;
                end
            end

            if (coll_fire) begin
                coll_ptr  <= next_idx(c_sel);
                coll_lock <= 1'b0;
            end else if (px_val_i) begin
                coll_lock <= 1'b1;
                lock_idx  <= c_sel;
            end

            outst <= out_nx;
        end
    end

`ifdef PERF_COUNT_EN
    logic [31:0] perf_cnt, perf_inc;

    assign perf_inc = (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;

    // The DRAIN->DONE edge is itself a busy cycle, so the copy includes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt     <= '0;
            frame_cycles <= '0;
        end else begin
            if (frame_start)  perf_cnt <= '0;
            else if (active)  perf_cnt <= perf_inc;
            if (state == DRAIN && state_nx == DONE) frame_cycles <= perf_inc;
        end
    end
`else
    assign frame_cycles = '0;
`endif
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// tb/tb_mandel_pixel_scheduler.sv - table-driven bench with stub workers for mandel_pixel_scheduler
module tb_mandel_pixel_scheduler;
    localparam int NW = 2;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int IW = 11;
    localparam int AW = 19;
    localparam logic [26:0] CR0 = 27'h7000000;
    localparam logic [26:0] CI0 = 27'h0800000;
    localparam logic [26:0] DXV = 27'h0400000;
    localparam logic [26:0] DYV = 27'h7C00000;

    typedef struct {
        bit w0_off;
        int stall_at;
        int stall_len;
        int start_at;
        int exp_w1;
        bit exp_alt;
    } vec_t;

    typedef struct {
        int          w;
        logic [26:0] cr;
        logic [26:0] ci;
    } disp_t;

    logic        clk = 1'b0;
    logic        reset, start, busy, frame_done;
    logic [26:0] cr_origin, ci_origin, dx, dy;
    logic [31:0] frame_cycles;
    logic [NW-1:0] w_dis, w_busy, w_val;
    logic [2:0]    w_cnt [NW];
    logic [IW-1:0] w_iter [NW];

    int n_chk = 0, n_err = 0;
    int seen [HR*VR];
    int px_cnt, fd_cnt, busy_cyc, outst, max_out;
    disp_t disp_q [$];
    logic pv_prev, pr_prev;
    logic [AW-1:0] pa_prev;
    logic [IW-1:0] pi_prev;
    vec_t vecs [4];

    mandel_pixel_scheduler_if #(.N_ITER(NW), .ITER_W(IW), .ADDR_W(AW)) bus ();

    mandel_pixel_scheduler #(.N_ITER(NW), .H_RES(HR), .V_RES(VR), .ITER_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cr_origin(cr_origin), .ci_origin(ci_origin), .dx(dx), .dy(dy),
        .busy(busy), .frame_done(frame_done), .frame_cycles(frame_cycles),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stub worker result: recover (x,y) from the coordinates, return y*HR+x+1.
    function automatic logic [IW-1:0] model_iter(input logic [26:0] cr, input logic [26:0] ci);
        logic [26:0] ox, oy;
        ox = cr - CR0;
        oy = CI0 - ci;
        return IW'((oy >> 22) * HR + (ox >> 22) + 1);
    endfunction

    always_comb begin
        bus.wk_in_rdy  = ~w_busy & ~w_dis;
        bus.wk_out_val = w_val;
        bus.wk_iter    = {w_iter[1], w_iter[0]};
    end

    always @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (!reset) begin
                w_busy[i] <= 1'b0;
                w_val[i]  <= 1'b0;
                w_cnt[i]  <= 3'd0;
                w_iter[i] <= '0;
            end else if (bus.wk_in_val[i] && !w_busy[i] && !w_dis[i]) begin
                w_busy[i] <= 1'b1;
                w_cnt[i]  <= 3'd3;
                w_iter[i] <= model_iter(bus.wk_c_r[27*i +: 27], bus.wk_c_i[27*i +: 27]);
            end else if (w_busy[i] && !w_val[i]) begin
                if (w_cnt[i] == 3'd1) w_val[i] <= 1'b1;
                w_cnt[i] <= w_cnt[i] - 3'd1;
            end else if (w_val[i] && bus.wk_out_rdy[i]) begin
                w_val[i]  <= 1'b0;
                w_busy[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            outst   = 0;
            pv_prev = 1'b0;
            pr_prev = 1'b1;
        end else begin
            for (int i = 0; i < NW; i++)
                if (bus.wk_in_val[i] && bus.wk_in_rdy[i]) begin
                    disp_q.push_back('{i, bus.wk_c_r[27*i +: 27], bus.wk_c_i[27*i +: 27]});
                    outst++;
                end
            if (pv_prev && !pr_prev) begin
                chk("stall_hold_val", bus.px_val, 1'b1);
                chk("stall_hold_addr", bus.px_addr, pa_prev);
                chk("stall_hold_iter", bus.px_iter, pi_prev);
            end
            if (bus.px_val && bus.px_rdy) begin
                chk("px_iter", bus.px_iter, 64'(bus.px_addr) + 1);
                if (bus.px_addr < AW'(HR*VR)) seen[bus.px_addr]++;
                px_cnt++;
                outst--;
            end
            if (outst > max_out) max_out = outst;
            if (busy) busy_cyc++;
            if (frame_done) fd_cnt++;
            pv_prev = bus.px_val;
            pr_prev = bus.px_rdy;
            pa_prev = bus.px_addr;
            pi_prev = bus.px_iter;
        end
    end

    task automatic run_frame(input vec_t v);
        int cyc, uniq, n1, rr_bad;
        logic [31:0] exp_fc;
        w_dis = v.w0_off ? 2'b01 : 2'b00;
        foreach (seen[k]) seen[k] = 0;
        px_cnt = 0; fd_cnt = 0; busy_cyc = 0; max_out = 0;
        disp_q.delete();
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        cyc = 0;
        while (fd_cnt == 0 && cyc < 1000) begin
            if (cyc == v.stall_at) bus.px_rdy = 1'b0;
            if (cyc == v.stall_at + v.stall_len) bus.px_rdy = 1'b1;
            start = (cyc == v.start_at);
            @(posedge clk); #2;
            cyc++;
        end
        start = 1'b0;
        bus.px_rdy = 1'b1;
        chk("frame_done_seen", fd_cnt != 0, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        uniq = 0;
        foreach (seen[k]) if (seen[k] == 1) uniq++;
        chk("px_count", px_cnt, HR*VR);
        chk("addrs_once", uniq, HR*VR);
        chk("frame_done_count", fd_cnt, 1);
        chk("busy_after", busy, 1'b0);
        chk("dispatch_count", disp_q.size(), HR*VR);
        chk("max_outstanding_ok", max_out <= NW, 1'b1);
        n1 = 0; rr_bad = 0;
        foreach (disp_q[k]) begin
            if (disp_q[k].w == 1) n1++;
            if (disp_q[k].w != k % 2) rr_bad++;
        end
        chk("w1_dispatches", n1, v.exp_w1);
        if (v.exp_alt) chk("rr_order", rr_bad, 0);
        if (disp_q.size() > 5) begin
            chk("px3_cr", disp_q[3].cr, 27'h7C00000);
            chk("px4_cr_line_start", disp_q[4].cr, 27'h7000000);
            chk("px4_ci", disp_q[4].ci, 27'h0400000);
            chk("px5_cr", disp_q[5].cr, 27'h7400000);
            chk("px5_ci", disp_q[5].ci, 27'h0400000);
        end
`ifdef PERF_COUNT_EN
        exp_fc = 32'(busy_cyc);
`else
        exp_fc = 32'd0;
`endif
        chk("frame_cycles", frame_cycles, exp_fc);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        cr_origin = CR0; ci_origin = CI0; dx = DXV; dy = DYV;
        bus.px_rdy = 1'b1;
        w_dis = 2'b00;
        px_cnt = 0; fd_cnt = 0; busy_cyc = 0; outst = 0; max_out = 0;
        foreach (seen[k]) seen[k] = 0;

        vecs[0] = '{w0_off: 1'b0, stall_at: -1, stall_len: 0,  start_at: -1, exp_w1: 4, exp_alt: 1'b1};
        vecs[1] = '{w0_off: 1'b0, stall_at: 6,  stall_len: 20, start_at: 10, exp_w1: 4, exp_alt: 1'b1};
        vecs[2] = '{w0_off: 1'b1, stall_at: -1, stall_len: 0,  start_at: -1, exp_w1: 8, exp_alt: 1'b0};
        vecs[3] = '{w0_off: 1'b1, stall_at: 3,  stall_len: 20, start_at: 4,  exp_w1: 8, exp_alt: 1'b0};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_wk_in_val", bus.wk_in_val, 2'b00);
        chk("rst_wk_out_rdy", bus.wk_out_rdy, 2'b00);
        chk("rst_px_val", bus.px_val, 1'b0);
        chk("rst_px_addr", bus.px_addr, '0);
        chk("rst_px_iter", bus.px_iter, '0);
        chk("rst_frame_cycles", frame_cycles, 32'd0);
        reset = 1'b1;
        @(posedge clk); #2;

        for (int v = 0; v < 4; v++) run_frame(vecs[v]);

        // Mid-RUN reset: abandon the frame, then a clean frame must follow.
        w_dis = 2'b00;
        fd_cnt = 0;
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("midrun_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_wk_in_val", bus.wk_in_val, 2'b00);
        chk("async_rst_px_val", bus.px_val, 1'b0);
        chk("async_rst_px_addr", bus.px_addr, '0);
        chk("async_rst_frame_done", frame_done, 1'b0);
        chk("async_rst_frame_cycles", frame_cycles, 32'd0);
        @(posedge clk); #2; reset = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        chk("no_frame_done_after_reset", fd_cnt, 0);
        chk("idle_after_reset", busy, 1'b0);
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
